// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the EX stage and the iterative mul/div unit.
interface muldiv_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    // Pipeline side issues requests and watches busy/done.
    modport master (
        output start, op, rs1_data, rs2_data, flush,
        input  busy, done, result
    );

    // Unit side consumes requests and drives status/result.
    modport slave (
        input  start, op, rs1_data, rs2_data, flush,
        output busy, done, result
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one operand bit per cycle, fixed 32-cycle
// CALC phase for every op, one-cycle DONE pulse carrying the result.
module muldiv_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic          clk,
    input  logic          reset_n,
    muldiv_unit_if.slave  bus
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StCalc = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    localparam int unsigned AccW = 2 * XLEN;

    logic [1:0]      state_q, state_d;
    logic [4:0]      cnt_q, cnt_d;
    logic [2:0]      op_q, op_d;
    logic [AccW-1:0] acc_q, acc_d;      // mul: {partial, multiplier}; div: {rem, quotient}
    logic [XLEN-1:0] opnd_q, opnd_d;    // mul: multiplicand magnitude; div: divisor magnitude
    logic [XLEN-1:0] a_raw_q, a_raw_d;  // original dividend, returned by REM on divide-by-zero
    logic            neg_q, neg_d;      // product / quotient sign
    logic            rem_neg_q, rem_neg_d;
    logic            divz_q, divz_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic            accept;
    logic            a_sgn, b_sgn, a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic [XLEN:0]   mul_sum;
    logic [AccW-1:0] mul_next;
    logic [XLEN:0]   div_hi;
    logic            div_ge;
    logic [XLEN-1:0] div_rem;
    logic [AccW-1:0] div_next;
    logic [AccW-1:0] prod;
    logic [XLEN-1:0] q_mag, r_mag;
    logic [XLEN-1:0] final_res;

    // Operand sign/magnitude decode for a new request.
    always_comb begin
        // op[2]=1: divide, signed when op[0]=0. op[2]=0: MUL/MULH both signed, MULHSU A only.
        a_sgn = bus.op[2] ? ~bus.op[0] : (bus.op[1:0] != 2'b11);
        b_sgn = bus.op[2] ? ~bus.op[0] : ~bus.op[1];
        a_neg = a_sgn & bus.rs1_data[XLEN-1];
        b_neg = b_sgn & bus.rs2_data[XLEN-1];
        a_mag = a_neg ? -bus.rs1_data : bus.rs1_data;
        b_mag = b_neg ? -bus.rs2_data : bus.rs2_data;
        accept = ((state_q == StIdle) || (state_q == StDone)) && bus.start && !bus.flush;
    end

    // One shift-add multiply step and one restoring divide step.
    always_comb begin
        mul_sum  = {1'b0, acc_q[AccW-1:XLEN]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
        mul_next = {mul_sum, acc_q[XLEN-1:1]};
        div_hi   = acc_q[AccW-1:XLEN-1];
        div_ge   = (div_hi >= {1'b0, opnd_q});
        // Trial result is below the divisor whenever div_ge holds, so XLEN bits suffice.
        div_rem  = div_hi[XLEN-1:0] - opnd_q;
        div_next = div_ge ? {div_rem, acc_q[XLEN-2:0], 1'b1}
                          : {div_hi[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end

    // Sign fix-up and special cases applied on the last iteration.
    always_comb begin
        prod  = neg_q ? -mul_next : mul_next;
        q_mag = div_next[XLEN-1:0];
        r_mag = div_next[AccW-1:XLEN];
        // Signed overflow needs no special path: |A|=2^31, |B|=1 gives quotient
        // magnitude 0x80000000 with positive sign and remainder 0.
        unique case (op_q)
            3'b000:  final_res = prod[XLEN-1:0];
            3'b001,
            3'b010,
            3'b011:  final_res = prod[AccW-1:XLEN];
            3'b100:  final_res = divz_q ? '1 : (neg_q ? -q_mag : q_mag);
            3'b101:  final_res = divz_q ? '1 : q_mag;
            3'b110:  final_res = divz_q ? a_raw_q : (rem_neg_q ? -r_mag : r_mag);
            default: final_res = divz_q ? a_raw_q : r_mag;
        endcase
    end

    // FSM sequencing, iteration and request capture.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        a_raw_d   = a_raw_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        divz_d    = divz_q;
        result_d  = result_q;

        case (state_q)
            StIdle: begin
                if (accept) state_d = StCalc;
            end
            StCalc: begin
                if (bus.flush) begin
                    state_d = StIdle;
                end else begin
                    acc_d = op_q[2] ? div_next : mul_next;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_d  = StDone;
                        result_d = final_res;
                    end
                end
            end
            StDone: begin
                state_d = accept ? StCalc : StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (accept) begin
            cnt_d     = 5'd0;
            op_d      = bus.op;
            acc_d     = {{XLEN{1'b0}}, (bus.op[2] ? a_mag : b_mag)};
            opnd_d    = bus.op[2] ? b_mag : a_mag;
            a_raw_d   = bus.rs1_data;
            neg_d     = a_neg ^ b_neg;
            rem_neg_d = a_neg;
            divz_d    = (bus.rs2_data == '0);
        end

        busy_d = (state_d == StCalc);
        done_d = (state_d == StDone);
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            op_q      <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            a_raw_q   <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            divz_q    <= 1'b0;
            result_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            a_raw_q   <= a_raw_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            divz_q    <= divz_d;
            result_q  <= result_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomised and directed bench for muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] last_res;

    muldiv_unit_if bus ();

    muldiv_unit dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // RV32M semantics in plain 64-bit / 32-bit arithmetic.
    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     p;
        int              ia, ib;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        ia = a;
        ib = b;
        case (op)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return ia / ib;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return ia % ib;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    task automatic scramble();
        bus.op       = 3'($urandom);
        bus.rs1_data = $urandom;
        bus.rs2_data = $urandom;
    endtask

    // Present a request for one cycle; returns just after the sampling edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.flush    = 1'b0;
        bus.op       = op;
        bus.rs1_data = a;
        bus.rs2_data = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        scramble();
    endtask

    task automatic run_check(input string tag, input logic [2:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] exp);
        int nb = 0;
        int nd = 0;
        issue(op, a, b);
        for (int i = 1; i <= 32; i++) begin
            @(negedge clk);
            if (bus.busy) nb++;
            if (bus.done) nd++;
            scramble();
        end
        @(negedge clk);
        check_eq({tag, " busy_cycles"}, nb, 32);
        check_eq({tag, " early_done"}, nd, 0);
        check_eq({tag, " done"}, {31'd0, bus.done}, 1);
        check_eq({tag, " busy_at_done"}, {31'd0, bus.busy}, 0);
        check_eq({tag, " result"}, bus.result, exp);
        @(negedge clk);
        check_eq({tag, " done_pulse"}, {31'd0, bus.done}, 0);
        check_eq({tag, " held"}, bus.result, exp);
        last_res = exp;
    endtask

    task automatic watch_idle(input string tag, input int cycles, input logic [31:0] exp_res);
        int nb = 0;
        int nd = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.busy) nb++;
            if (bus.done) nd++;
        end
        check_eq({tag, " busy"}, nb, 0);
        check_eq({tag, " done"}, nd, 0);
        check_eq({tag, " result"}, bus.result, exp_res);
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b, exp;
        int          k;
        int          nd;

        reset_n      = 1'b0;
        bus.start    = 1'b0;
        bus.flush    = 1'b0;
        bus.op       = '0;
        bus.rs1_data = '0;
        bus.rs2_data = '0;
        last_res     = '0;
        repeat (3) @(negedge clk);
        check_eq("reset busy", {31'd0, bus.busy}, 0);
        check_eq("reset done", {31'd0, bus.done}, 0);
        check_eq("reset result", bus.result, 0);
        reset_n = 1'b1;

        // Directed cases with hand-derived results.
        run_check("mul_7x-3", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
        run_check("mulh_min", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        run_check("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_check("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF);
        run_check("div_-7/2", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        run_check("rem_-7/2", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        run_check("divu_100/7", 3'd5, 32'd100, 32'd7, 32'd14);
        run_check("remu_100/7", 3'd7, 32'd100, 32'd7, 32'd2);
        run_check("divu_by0", 3'd5, 32'h1234, 32'd0, 32'hFFFF_FFFF);
        run_check("rem_by0", 3'd6, 32'h1234, 32'd0, 32'h1234);
        run_check("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_check("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

        // Flush in cycle T+10 aborts with no done and result untouched.
        issue(3'd0, 32'd9, 32'd9);
        for (int i = 1; i <= 10; i++) @(negedge clk);
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        watch_idle("flush_calc", 40, last_res);

        // start together with flush in IDLE is not accepted.
        @(negedge clk);
        bus.start = 1'b1;
        bus.flush = 1'b1;
        bus.op    = 3'd5;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        watch_idle("start_flush_idle", 40, last_res);

        // start during CALC is ignored and not queued.
        exp = 32'd6;
        issue(3'd0, 32'd2, 32'd3);
        nd  = 0;
        for (int i = 1; i <= 32; i++) begin
            @(negedge clk);
            if (bus.done) nd++;
            bus.start = (i == 5);
            bus.op    = 3'd5;
        end
        @(negedge clk);
        check_eq("calc_start early_done", nd, 0);
        check_eq("calc_start done", {31'd0, bus.done}, 1);
        check_eq("calc_start result", bus.result, exp);
        last_res = exp;
        watch_idle("calc_start no_second", 40, last_res);

        // Asynchronous reset mid-CALC clears outputs immediately.
        issue(3'd2, 32'hDEAD_BEEF, 32'h1234_5678);
        repeat (15) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("async_rst busy", {31'd0, bus.busy}, 0);
        check_eq("async_rst done", {31'd0, bus.done}, 0);
        check_eq("async_rst result", bus.result, 0);
        @(negedge clk);
        reset_n  = 1'b1;
        last_res = '0;
        watch_idle("after_rst", 40, last_res);

        // Back-to-back: start held in DONE gives the next done exactly 33 cycles later.
        issue(3'd5, 32'd100, 32'd7);
        repeat (32) @(negedge clk);
        @(negedge clk);
        check_eq("b2b first_done", {31'd0, bus.done}, 1);
        check_eq("b2b first_result", bus.result, 32'd14);
        bus.start    = 1'b1;
        bus.op       = 3'd7;
        bus.rs1_data = 32'd100;
        bus.rs2_data = 32'd7;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        scramble();
        k = 0;
        for (int i = 1; i <= 40 && k == 0; i++) begin
            @(negedge clk);
            if (bus.done) k = i;
        end
        check_eq("b2b latency", k, 33);
        check_eq("b2b second_result", bus.result, 32'd2);
        last_res = 32'd2;
        @(negedge clk);

        // Random operations against the reference model.
        for (int n = 0; n < 40; n++) begin
            op  = 3'($urandom);
            a   = pick_val();
            b   = pick_val();
            exp = ref_model(op, a, b);
            run_check($sformatf("rand%0d op%0d a=%08h b=%08h", n, op, a, b), op, a, b, exp);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
